// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Tracks the instructions that have left the decode (D) stage through
// NSTAGE later stages (1=E, 2=M, 3=W for the default depth).  From that
// record it produces:
//   - Stall  : D must hold and a bubble enters E, because a source operand
//              cannot be forwarded in time or the mult/div unit is busy.
//   - Fwd_Rs / Fwd_Rt : per consumer stage s (0=D .. NSTAGE-1), the index of
//              the stage whose result should be forwarded, 0 = register file.
//   - Stall_Cnt : stall-cycle counter (only with HZD_STATS_EN).
//
// Ports
//   Clk, Reset_n            clock (rising edge), asynchronous active-low reset
//   D_Valid                 D stage holds a real instruction
//   D_Rs, D_Rt              D source register addresses
//   D_Rs_Use, D_Rt_Use      source is actually read
//   D_Tuse_Rs, D_Tuse_Rt    cycles from D until the operand is needed
//   D_Dst                   destination register (0 = none)
//   D_Tnew                  cycles after entering E until the result exists
//   D_MuDi, MuDiBusy        D needs the mult/div unit; that unit is busy
//   Flush                   kill every tracked stage
//   Stall                   hold PC and D, bubble into E (combinational)
//   Fwd_Rs, Fwd_Rt          NSTAGE slices of SW bits, slice s = stage s
//   Stall_Cnt               32-bit stall-cycle count
//
// Configuration macro
//   HZD_STATS_EN  defined   : Stall_Cnt counts edges with Stall=1, Flush=0
//                 undefined : Stall_Cnt is tied to 0, no counter flops
//
// There is no FSM and no valid/ready handshake in this block: D_Valid is a
// plain qualifier and Stall is an unconditional hold request to the pipe.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_AW = 6,
  parameter int NSTAGE = 3,
  parameter int TW     = 2,
  localparam int SW    = $clog2(NSTAGE + 1)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 D_Valid,
  input  logic [REG_AW-1:0]    D_Rs,
  input  logic [REG_AW-1:0]    D_Rt,
  input  logic                 D_Rs_Use,
  input  logic                 D_Rt_Use,
  input  logic [TW-1:0]        D_Tuse_Rs,
  input  logic [TW-1:0]        D_Tuse_Rt,
  input  logic [REG_AW-1:0]    D_Dst,
  input  logic [TW-1:0]        D_Tnew,
  input  logic                 D_MuDi,
  input  logic                 MuDiBusy,
  input  logic                 Flush,
  output logic                 Stall,
  output logic [NSTAGE*SW-1:0] Fwd_Rs,
  output logic [NSTAGE*SW-1:0] Fwd_Rt,
  output logic [31:0]          Stall_Cnt
);

  // One tracked stage. A bubble is simply the all-zero record.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
    logic [TW-1:0]     tnew;
  } stage_t;

  stage_t st_q [1:NSTAGE];
  stage_t st_d [1:NSTAGE];

  // Consumer source address per stage: index 0 is D, the rest are the
  // sources recorded in the tracked stages.
  logic [REG_AW-1:0] src_rs [0:NSTAGE-1];
  logic [REG_AW-1:0] src_rt [0:NSTAGE-1];

  logic          rs_late;
  logic          rt_late;
  logic          mudi_block;
  logic [SW-1:0] sel_rs;
  logic [SW-1:0] sel_rt;

  // Producer stage s writes register a. Register 0 never matches, so it
  // can neither stall nor forward.
  function automatic logic match_f(input stage_t s, input logic [REG_AW-1:0] a);
    return s.valid && (a != '0) && (s.dst == a);
  endfunction

  // ---------------------------------------------------------------------------
  // Stall detection. Stages are scanned oldest to youngest so the last hit
  // is the nearest producer; only that producer decides, older copies of the
  // same register are shadowed.
  // ---------------------------------------------------------------------------
  always_comb begin
    rs_late = 1'b0;
    rt_late = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (match_f(st_q[k], D_Rs)) rs_late = (st_q[k].tnew > D_Tuse_Rs);
      if (match_f(st_q[k], D_Rt)) rt_late = (st_q[k].tnew > D_Tuse_Rt);
    end
    mudi_block = D_MuDi && MuDiBusy;
    Stall = D_Valid && ((D_Rs_Use && rs_late) || (D_Rt_Use && rt_late) || mudi_block);
  end

  // ---------------------------------------------------------------------------
  // Forwarding selects. For consumer stage s only strictly older stages
  // (k > s) are candidates. A nearest producer whose result is not ready yet
  // yields 0 instead of falling through to an older, stale copy. The last
  // stage has no slice of its own: nothing older exists to forward from.
  // ---------------------------------------------------------------------------
  always_comb begin
    src_rs[0] = D_Rs;
    src_rt[0] = D_Rt;
    for (int s = 1; s < NSTAGE; s++) begin
      src_rs[s] = st_q[s].rs;
      src_rt[s] = st_q[s].rt;
    end
  end

  always_comb begin
    Fwd_Rs = '0;
    Fwd_Rt = '0;
    sel_rs = '0;
    sel_rt = '0;
    for (int s = 0; s < NSTAGE; s++) begin
      sel_rs = '0;
      sel_rt = '0;
      for (int k = NSTAGE; k >= 1; k--) begin
        if (k > s) begin
          if (match_f(st_q[k], src_rs[s]))
            sel_rs = (st_q[k].tnew == '0) ? SW'(k) : '0;
          if (match_f(st_q[k], src_rt[s]))
            sel_rt = (st_q[k].tnew == '0) ? SW'(k) : '0;
        end
      end
      Fwd_Rs[s*SW +: SW] = sel_rs;
      Fwd_Rt[s*SW +: SW] = sel_rt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage advance. Older stages always move on; stage 1 takes either the D
  // instruction or a bubble. Tnew counts down towards 0 and saturates there.
  // Flush wipes whole records (not just valid) so dead addresses cannot
  // leak into the consumer side of the forwarding compare.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 1; k <= NSTAGE; k++) st_d[k] = st_q[k];
    if (Flush) begin
      for (int k = 1; k <= NSTAGE; k++) st_d[k] = '0;
    end else begin
      for (int k = NSTAGE; k >= 2; k--) begin
        st_d[k]      = st_q[k-1];
        st_d[k].tnew = (st_q[k-1].tnew == '0) ? '0 : st_q[k-1].tnew - 1'b1;
      end
      if (Stall) begin
        st_d[1] = '0;
      end else begin
        st_d[1].valid = D_Valid;
        st_d[1].rs    = D_Rs;
        st_d[1].rt    = D_Rt;
        st_d[1].dst   = D_Dst;
        st_d[1].tnew  = D_Tnew;
      end
    end
  end

  // Asynchronous reset also discards a bubble that was about to be inserted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 1; k <= NSTAGE; k++) st_q[k] <= '0;
    end else begin
      for (int k = 1; k <= NSTAGE; k++) st_q[k] <= st_d[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Stall statistics. A flushed cycle does not count even if Stall was high;
  // the counter wraps naturally at 2^32.
  // ---------------------------------------------------------------------------
`ifdef HZD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= '0;
    end else if (Stall && !Flush) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
`else
  assign Stall_Cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Bench for hazard_scoreboard (default parameters). A table of D-stage
// vectors with expected Stall / Fwd_Rs / Fwd_Rt is applied in order, the
// pipeline contents carrying over from one record to the next. Hand-written
// sequences then cover flush during a stall, asynchronous reset mid-stall
// and the stall counter (HZD_STATS_EN aware).
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int REG_AW = 6;
  localparam int NSTAGE = 3;
  localparam int TW     = 2;
  localparam int SW     = 2;
  localparam int FW     = NSTAGE * SW;
  localparam int EW     = 1 + 2 * FW;
  localparam int NV     = 19;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  logic              D_Valid;
  logic [REG_AW-1:0] D_Rs, D_Rt, D_Dst;
  logic              D_Rs_Use, D_Rt_Use;
  logic [TW-1:0]     D_Tuse_Rs, D_Tuse_Rt, D_Tnew;
  logic              D_MuDi, MuDiBusy, Flush;
  logic              Stall;
  logic [FW-1:0]     Fwd_Rs, Fwd_Rt;
  logic [31:0]       Stall_Cnt;

  hazard_scoreboard #(.REG_AW(REG_AW), .NSTAGE(NSTAGE), .TW(TW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .D_Valid(D_Valid), .D_Rs(D_Rs), .D_Rt(D_Rt),
    .D_Rs_Use(D_Rs_Use), .D_Rt_Use(D_Rt_Use),
    .D_Tuse_Rs(D_Tuse_Rs), .D_Tuse_Rt(D_Tuse_Rt),
    .D_Dst(D_Dst), .D_Tnew(D_Tnew),
    .D_MuDi(D_MuDi), .MuDiBusy(MuDiBusy), .Flush(Flush),
    .Stall(Stall), .Fwd_Rs(Fwd_Rs), .Fwd_Rt(Fwd_Rt), .Stall_Cnt(Stall_Cnt)
  );

  // ---------------- vector record ----------------
  typedef struct {
    logic              flush;
    logic              d_valid;
    logic [REG_AW-1:0] rs, rt, dst;
    logic              rs_use, rt_use;
    logic [TW-1:0]     tuse_rs, tuse_rt, tnew;
    logic              mudi, busy;
    logic              exp_stall;
    logic [FW-1:0]     exp_fwd_rs, exp_fwd_rt;
  } vec_t;

  vec_t vecs [NV];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec   = 0;
  int n_err   = 0;
  int exp_cnt = 0;

  function automatic vec_t mkv(input logic dv, input int rs, input int rt,
                               input logic rsu, input logic rtu,
                               input int tur, input int tut,
                               input int dst, input int tn,
                               input logic mudi, input logic busy,
                               input logic stall, input int frs, input int frt);
    vec_t v;
    v.flush      = 1'b0;
    v.d_valid    = dv;
    v.rs         = REG_AW'(rs);
    v.rt         = REG_AW'(rt);
    v.rs_use     = rsu;
    v.rt_use     = rtu;
    v.tuse_rs    = TW'(tur);
    v.tuse_rt    = TW'(tut);
    v.dst        = REG_AW'(dst);
    v.tnew       = TW'(tn);
    v.mudi       = mudi;
    v.busy       = busy;
    v.exp_stall  = stall;
    v.exp_fwd_rs = FW'(frs);
    v.exp_fwd_rt = FW'(frt);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    Flush     = v.flush;
    D_Valid   = v.d_valid;
    D_Rs      = v.rs;
    D_Rt      = v.rt;
    D_Rs_Use  = v.rs_use;
    D_Rt_Use  = v.rt_use;
    D_Tuse_Rs = v.tuse_rs;
    D_Tuse_Rt = v.tuse_rt;
    D_Dst     = v.dst;
    D_Tnew    = v.tnew;
    D_MuDi    = v.mudi;
    MuDiBusy  = v.busy;
  endtask

  task automatic push_exp(input logic stall, input logic [FW-1:0] frs,
                          input logic [FW-1:0] frt);
    exp_q.push_back({stall, frs, frt});
  endtask

  task automatic check_out(input int id);
    logic [EW-1:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL vec%0d: no expected entry queued", id);
    end else begin
      e = exp_q.pop_front();
      if ({Stall, Fwd_Rs, Fwd_Rt} !== e) begin
        n_err++;
        $display("FAIL vec%0d: stall/fwd_rs/fwd_rt got %b/%b/%b expected %b/%b/%b",
                 id, Stall, Fwd_Rs, Fwd_Rt, e[EW-1], e[2*FW-1:FW], e[FW-1:0]);
      end
    end
  endtask

  task automatic check_cnt(input int id);
    logic [31:0] e;
`ifdef HZD_STATS_EN
    e = 32'(exp_cnt);
`else
    e = 32'd0;
`endif
    n_vec++;
    if (Stall_Cnt !== e) begin
      n_err++;
      $display("FAIL cnt%0d: Stall_Cnt got %0d expected %0d", id, Stall_Cnt, e);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, outputs are sampled on
  // the falling edge, then the rising edge commits the cycle.
  task automatic apply(input vec_t v, input int id);
    drive(v);
    push_exp(v.exp_stall, v.exp_fwd_rs, v.exp_fwd_rt);
    @(negedge Clk);
    check_out(id);
    @(posedge Clk);
    #1;
    if (v.exp_stall && !v.flush) exp_cnt++;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    vec_t v;

    //           dv rs rt ru tu tr tt dst tn md by  st frs frt
    vecs[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0); // idle
    vecs[1]  = mkv(1, 1, 2, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0,  0); // load -> $5
    vecs[2]  = mkv(1, 5, 0, 1, 0, 0, 0, 6, 0, 0, 0, 1,  0,  0); // load-use stall
    vecs[3]  = mkv(1, 5, 0, 1, 0, 0, 0, 6, 0, 0, 0, 0,  2,  0); // fwd from M
    vecs[4]  = mkv(1, 5, 6, 0, 0, 0, 0, 3, 0, 0, 0, 0, 15,  1); // alu -> $3
    vecs[5]  = mkv(1, 0, 3, 0, 1, 0, 1, 0, 0, 0, 0, 0,  0,  9); // alu chain
    vecs[6]  = mkv(1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 56); // $7 older
    vecs[7]  = mkv(1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 48); // $7 younger
    vecs[8]  = mkv(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1,  0,  0); // shadowed
    vecs[9]  = mkv(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  2,  0);
    vecs[10] = mkv(1, 0, 0, 1, 1, 0, 0, 0, 3, 0, 0, 0, 12,  0); // $0 vs dst 0
    vecs[11] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  0,  0); // mudi busy
    vecs[12] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  0,  0);
    vecs[13] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0,  0); // unit free
    vecs[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0,  0); // no D
    vecs[15] = mkv(1, 0, 0, 0, 0, 0, 0, 9, 2, 0, 0, 0,  0,  0); // $9 tnew 2
    vecs[16] = mkv(1, 9, 9, 0, 1, 0, 2, 0, 0, 0, 0, 0,  0,  0); // tnew==tuse
    vecs[17] = mkv(1, 9, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1,  0,  0); // late in M
    vecs[18] = mkv(1, 9, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 51, 51); // fwd from W

    // reset state
    Reset_n = 1'b0;
    drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push_exp(1'b0, '0, '0);
    #12;
    check_out(0);
    check_cnt(0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < NV; i++) apply(vecs[i], i);
    check_cnt(90);

    // flush during a stall: the stall is killed and the pipe is empty after
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 5, 2, 0, 0, 0, 0, 0), 40);
    v = mkv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v.flush = 1'b1;
    apply(v, 41);
    apply(mkv(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 42);
    check_cnt(95);

    // asynchronous reset while a stall is pending
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0, 0), 50);
    drive(mkv(1, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    push_exp(1'b1, '0, '0);
    @(negedge Clk);
    check_out(51);
    #2;
    Reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    push_exp(1'b0, '0, '0);
    check_out(52);
    check_cnt(52);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    apply(mkv(1, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 53);

    // four stall cycles from the mult/div unit, then release
    for (int i = 0; i < 4; i++)
      apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), 60 + i);
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 64);
    check_cnt(99);

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
